// File: rtl/ysyx_22050710_epu_pkg.sv
// ----------------------------------------------------------------------------
// Module   : ysyx_22050710_epu_pkg
// Brief    : Shared CSR addresses, csr_op encodings and EPU state encodings.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ysyx_22050710_epu_pkg;

    localparam int c_ADDR_WIDTH = 12;
    localparam int c_DATA_WIDTH = 64;

    localparam logic [c_ADDR_WIDTH-1:0] c_MSTATUS = 12'h300;
    localparam logic [c_ADDR_WIDTH-1:0] c_MTVEC   = 12'h305;
    localparam logic [c_ADDR_WIDTH-1:0] c_MEPC    = 12'h341;
    localparam logic [c_ADDR_WIDTH-1:0] c_MCAUSE  = 12'h342;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CSR_RD   = 3'd1,
        S_CSR_WR   = 3'd2,
        S_TRAP     = 3'd3,
        S_RET      = 3'd4,
        S_REDIRECT = 3'd5
    } epu_state_e;

endpackage

`default_nettype wire

// File: rtl/ysyx_22050710_csr_alu.sv
// ----------------------------------------------------------------------------
// Module   : ysyx_22050710_csr_alu
// Brief    : Combinational write-data ALU for CSRRW / CSRRS / CSRRC.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ysyx_22050710_csr_alu
    import ysyx_22050710_epu_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [1:0]            i_op,
    input  logic [DATA_WIDTH-1:0] i_old,
    input  logic [DATA_WIDTH-1:0] i_src,
    output logic [DATA_WIDTH-1:0] o_wdata
);

    always_comb begin
        o_wdata = '0;
        case (i_op)
            OP_RW:   o_wdata = i_src;
            OP_RS:   o_wdata = i_old | i_src;
            OP_RC:   o_wdata = i_old & ~i_src;
            default: o_wdata = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_22050710_epu.sv
// ----------------------------------------------------------------------------
// Module   : ysyx_22050710_epu
// Brief    : Sequences Zicsr read-modify-write, ecall and mret with fetch redirect.
// Revision : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ysyx_22050710_epu
    import ysyx_22050710_epu_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [1:0]            i_csr_op,
    input  logic                  i_ecall,
    input  logic                  i_mret,
    input  logic                  i_src_zero,
    input  logic [DATA_WIDTH-1:0] i_pc,
    input  logic [ADDR_WIDTH-1:0] i_csr_addr,
    input  logic [DATA_WIDTH-1:0] i_src,
    output logic                  o_csr_ren,
    output logic [ADDR_WIDTH-1:0] o_csr_raddr,
    input  logic [DATA_WIDTH-1:0] i_csr_rdata,
    output logic                  o_csr_wen,
    output logic [ADDR_WIDTH-1:0] o_csr_waddr,
    output logic [DATA_WIDTH-1:0] o_csr_wdata,
    output logic                  o_ecall_sel,
    output logic                  o_mret_sel,
    output logic [DATA_WIDTH-1:0] o_epc,
    input  logic [DATA_WIDTH-1:0] i_mtvec,
    input  logic [DATA_WIDTH-1:0] i_mepc,
    output logic                  o_rd_wen,
    output logic [DATA_WIDTH-1:0] o_rd_wdata,
    output logic                  o_redirect_valid,
    output logic [DATA_WIDTH-1:0] o_redirect_pc,
    input  logic                  i_redirect_ready
);

    epu_state_e            r_state;
    epu_state_e            w_next;
    logic                  r_en;
    logic [1:0]            r_op;
    logic                  r_src_zero;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_src;
    logic [DATA_WIDTH-1:0] r_old;
    logic [DATA_WIDTH-1:0] r_target;
    logic [DATA_WIDTH-1:0] w_alu_wdata;
    logic                  w_ready;
    logic                  w_accept;

    // r_en keeps o_ready low while reset is held and for the reset cycle itself
    assign w_ready  = (r_state == S_IDLE) && r_en;
    assign w_accept = w_ready && i_valid;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_en    <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (i_ecall)                w_next = S_TRAP;
                    else if (i_mret)            w_next = S_RET;
                    else if (i_csr_op != OP_NONE) w_next = S_CSR_RD;
                    else                        w_next = S_IDLE;
                end
            end
            S_CSR_RD:   w_next = S_CSR_WR;
            S_CSR_WR:   w_next = S_IDLE;
            S_TRAP:     w_next = S_REDIRECT;
            S_RET:      w_next = S_REDIRECT;
            S_REDIRECT: if (i_redirect_ready) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_op       <= 2'b00;
            r_src_zero <= 1'b0;
            r_pc       <= '0;
            r_addr     <= '0;
            r_src      <= '0;
            r_old      <= '0;
            r_target   <= '0;
        end else begin
            if (w_accept) begin
                r_op       <= i_csr_op;
                r_src_zero <= i_src_zero;
                r_pc       <= i_pc;
                r_addr     <= i_csr_addr;
                r_src      <= i_src;
            end
            if (r_state == S_CSR_RD) begin
                r_old <= i_csr_rdata;
            end
            // Target is frozen on REDIRECT entry so it cannot move while unacknowledged
            if (r_state == S_TRAP) begin
                r_target <= i_mtvec & ~{{(DATA_WIDTH-2){1'b0}}, 2'b11};
            end else if (r_state == S_RET) begin
                r_target <= i_mepc;
            end
        end
    end

    ysyx_22050710_csr_alu #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_csr_alu (
        .i_op    (r_op),
        .i_old   (r_old),
        .i_src   (r_src),
        .o_wdata (w_alu_wdata)
    );

    assign o_ready          = w_ready;
    assign o_csr_ren        = (r_state == S_CSR_RD);
    assign o_csr_raddr      = r_addr;
    // Set/clear with a zero source must not touch the CSR (no side effects)
    assign o_csr_wen        = (r_state == S_CSR_WR) && ((r_op == OP_RW) || !r_src_zero);
    assign o_csr_waddr      = r_addr;
    assign o_csr_wdata      = w_alu_wdata;
    assign o_ecall_sel      = (r_state == S_TRAP);
    assign o_mret_sel       = (r_state == S_RET);
    assign o_epc            = r_pc;
    assign o_rd_wen         = (r_state == S_CSR_WR);
    assign o_rd_wdata       = r_old;
    assign o_redirect_valid = (r_state == S_REDIRECT);
    assign o_redirect_pc    = r_target;

endmodule

`default_nettype wire

// File: doc/ysyx_22050710_epu.md
# ysyx_22050710_epu

Exception/CSR processing unit that issues CSR read and write commands and ecall/mret events to the CSR register file. It sits after decode, beside the execute stage. It sequences Zicsr read-modify-write instructions and trap entry/return as short multi-cycle operations. Trap entry and return end in a PC redirect handshake with the fetch stage.

## Interface
- ADDR_WIDTH, 12, CSR address width
- DATA_WIDTH, 64, CSR/GPR data width

Ports:
- i_clk  in  1  clock; all state changes on its rising edge
- i_rst_n  in  1  reset; synchronous and active-low
- i_valid  in  1  decoder offers one CSR/ecall/mret instruction
- o_ready  out  1  EPU can accept; high only in IDLE
- i_csr_op  in  2  00 none, 01 RW, 10 RS, 11 RC; the decoder has already muxed rs1 versus zimm
- i_ecall  in  1  instruction is ecall
- i_mret  in  1  instruction is mret
- i_src_zero  in  1  rs1 index (or zimm) is 0
- i_pc  in  DATA_WIDTH  PC of offered instruction
- i_csr_addr  in  ADDR_WIDTH  CSR target
- i_src  in  DATA_WIDTH  operand (rs1 value or zero-extended zimm)
- o_csr_ren / o_csr_raddr  out  1 / ADDR_WIDTH  CSR read port
- i_csr_rdata  in  DATA_WIDTH  combinational read data from the CSR file
- o_csr_wen / o_csr_waddr / o_csr_wdata  out  1 / ADDR_WIDTH / DATA_WIDTH  CSR write port
- o_ecall_sel, o_mret_sel  out  1  trap-entry and trap-return event strobes
- o_epc  out  DATA_WIDTH  PC to save as mepc
- i_mtvec, i_mepc  in  DATA_WIDTH  current mtvec and mepc
- o_rd_wen / o_rd_wdata  out  1 / DATA_WIDTH  GPR writeback of the old CSR value
- o_redirect_valid / o_redirect_pc  out  1 / DATA_WIDTH  fetch redirect
- i_redirect_ready  in  1  fetch accepts the redirect

## Operation
- FSM states: IDLE, CSR_RD, CSR_WR, TRAP, RET, REDIRECT.
- Acceptance happens when i_valid and o_ready are both high. The instruction's fields are latched at acceptance.
- Priority at acceptance: ecall, then mret, then CSR op. A lower-priority request is dropped.
  - Accepting with all three inputs inactive (i_ecall=0, i_mret=0, i_csr_op=00) is a no-op; the FSM stays in IDLE.
- IDLE to CSR_RD:
  - In CSR_RD: o_csr_ren=1 and o_csr_raddr is the latched address.
  - i_csr_rdata is captured into the register old.
- CSR_RD to CSR_WR:
  - In CSR_WR: o_rd_wen=1 and o_rd_wdata=old.
  - o_csr_wdata is computed from the op:
    - RW: src
    - RS: old | src
    - RC: old & ~src
  - o_csr_wen=1, except RS/RC with i_src_zero latched high, which give o_csr_wen=0. RW always writes.
- CSR_WR goes to IDLE.
- IDLE to TRAP (ecall):
  - In TRAP: o_ecall_sel=1 and o_epc is the latched pc.
  - The CSR file updates mepc and mcause (value 11) on this edge.
  - TRAP goes to REDIRECT with target {i_mtvec[DATA_WIDTH-1:2], 2'b00} (direct mode only). The target is sampled on REDIRECT entry and held.
- IDLE to RET (mret):
  - In RET: o_mret_sel=1, and mstatus is restored by the CSR file.
  - RET goes to REDIRECT with target i_mepc, sampled on REDIRECT entry.
- REDIRECT:
  - o_redirect_valid=1 and o_redirect_pc is held stable.
  - Leaves to IDLE on the edge where i_redirect_ready=1.
- o_ecall_sel, o_mret_sel and o_csr_wen are never high in the same cycle. The CSR file's ecall path must never collide with a software write.
- Width rules: all data is DATA_WIDTH wide with no extension. The address is passed through unmodified.

## Timing
- Reset (i_rst_n=0 at a rising edge) sends the FSM to IDLE.
  - During reset, o_ready=0 and every strobe, write enable and valid is 0.
  - All data outputs are 0 during and after reset until driven.
- Reset asserted mid-operation aborts the operation with no pending CSR write, GPR write or redirect.
- CSR op latency: accepted at cycle 0; read in cycle 1; CSR write and GPR writeback in cycle 2; o_ready=1 again in cycle 3.
- ecall/mret latency: accepted at cycle 0; strobe in cycle 1; o_redirect_valid first high in cycle 2. o_ready returns 1 the cycle after the handshake.
- While o_redirect_valid=1 is not yet accepted, o_redirect_valid and o_redirect_pc must not change.
- All outputs are registered-state decodes. No output depends combinationally on i_valid.

## Structure
- The shared defines header holds:
  - the CSR address constants MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342;
  - the csr_op encodings;
  - the FSM state encodings.
- The block is a single module. The RW/RS/RC write-data ALU is natural as a combinational sub-module, ysyx_22050710_csr_alu.

## Test plan
- CSRRW 0x305, src=0x80000100, old=0: cycle 1 has ren; cycle 2 has wen, wdata=0x80000100, rd_wdata=0; o_ready returns in cycle 3.
- CSRRS 0x300 with old=0xa00001800:
  - src=0x8: wdata=0xa00001808.
  - Repeat with i_src_zero=1: o_csr_wen stays 0 and rd_wdata=0xa00001800.
- CSRRC 0x342, old=0xb, src=0x3: wdata=0x8.
- ecall at pc=0x80000040 with mtvec=0x80000103:
  - TRAP cycle has ecall_sel=1 and epc=0x80000040.
  - Redirect target is 0x80000100.
  - Hold i_redirect_ready=0 for 3 cycles; valid and pc stay stable.
- mret with mepc=0x80000044: mret_sel pulse, then redirect to 0x80000044. Also check ecall and mret offered together yields ecall behaviour.
- Assert reset during CSR_RD and during REDIRECT: no wen, rd_wen, ecall_sel or redirect afterwards, and o_ready=1 one cycle after reset release.
